wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone classic arbiter.
- Lets the CPU instruction bus (iwb) and data bus (dwb) share a single unified wb_ram-style memory.
- Round-robin grant, one transfer per grant, with a bus-timeout watchdog that returns err to the stalled master.
- Sits between the CPU's iwb/dwb ports and the shared RAM in the top-level bench and SoC.

Parameters:
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- TIMEOUT, 255, cycles in BUSY without slave ack before err is raised; 0 disables the watchdog.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_iwb_addr/io_iwb_wdata/io_iwb_sel/io_iwb_we/io_iwb_cyc/io_iwb_stb  in  AW/DW/DW/8/1/1/1  instruction master request
- io_iwb_rdata  out  DW  read data to iwb
- io_iwb_ack  out  1  transfer complete, iwb
- io_iwb_err  out  1  timeout abort, iwb
- io_dwb_*  same set as iwb  data master
- io_swb_addr/io_swb_wdata/io_swb_sel/io_swb_we/io_swb_cyc/io_swb_stb  out  AW/DW/DW/8/1/1/1  to slave
- io_swb_rdata  in  DW  slave read data
- io_swb_ack  in  1  slave ack
- io_grant  out  2  one-hot owner: bit0 iwb, bit1 dwb; 00 when idle

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Request definition: a master requests when its cyc & stb are both high.
- State register is {IDLE, BUSY} plus grant_d (1 = dwb owns the bus), last_d (last served master) and a timeout counter tmo.
- IDLE:
  - No request: stay in IDLE.
  - One request: BUSY with that master.
  - Both request: grant the master that was not last served (~last_d).
  - On grant, load tmo = 0.
- BUSY outputs:
  - io_swb_* are a combinational mux of the granted master's addr/wdata/sel/we/cyc/stb.
  - Granted master gets rdata = io_swb_rdata and ack = io_swb_ack.
  - Non-granted master sees ack = 0, err = 0, rdata = 0.
- IDLE outputs: io_swb_cyc = io_swb_stb = 0, other swb outputs 0, both acks/errs 0, io_grant = 00.
- BUSY exits (priority order):
  - io_swb_ack = 1: go to IDLE, last_d <= grant_d.
  - Granted master drops cyc: abort, go to IDLE, last_d <= grant_d, no ack or err is delivered.
  - TIMEOUT != 0 and tmo == TIMEOUT-1: assert err to the granted master for exactly this cycle, drive io_swb_stb = 0 this cycle, go to IDLE, last_d <= grant_d.
  - Otherwise tmo <= tmo + 1. tmo is $clog2(TIMEOUT+1) bits and saturates; it never wraps.
- Latency:
  - Request sampled at edge N, grant registered at N.
  - Slave sees the request during cycle N+1; a single-cycle slave acks at edge N+2.
  - End-to-end, 1 idle cycle is added versus a direct connection.
- Back-to-back operation:
  - After an ack, the FSM is forced to IDLE for one cycle. The slave therefore never sees stb in the cycle after ack, so no duplicate access occurs against slaves guarded by ~ack.
  - A still-asserted request is re-arbitrated in that IDLE cycle.
  - With both masters requesting continuously, grants alternate i, d, i, d.
- Stray slave ack: an io_swb_ack seen in IDLE (e.g. a late ack after an abort) is ignored and not routed.
- Reset values:
  - State IDLE, grant_d = 0, last_d = 1 (iwb wins the first tie), tmo = 0.
  - All outputs are 0 from the cycle after reset is sampled, including mid-transfer.
  - The slave's in-flight ack is then swallowed per the stray-ack rule.
- Master ack is never asserted without that master's cyc high.

Decomposition:
- Shared package (wb_pkg):
  - AW/DW defaults.
  - FSM state encoding (IDLE=0, BUSY=1).
  - Grant index constants (GNT_I=0, GNT_D=1).
  - Wishbone request/response bundle typedefs, reused by future slaves and interconnect.
- One natural sub-module: wb_rr_pick2.
  - Combinational round-robin selector.
  - Inputs: req[1:0], last.
  - Outputs: gnt, valid.
- FSM, muxing and watchdog stay in wb_arbiter2.

Test Plan:
- iwb only reads addr 0x10 (RAM word 0xDEADBEEF) -> io_swb_stb high 1 cycle after request; io_iwb_ack 2 cycles after request with rdata 0xDEADBEEF; io_dwb_ack stays 0; io_grant 01 during BUSY.
- Both request from reset (iwb read 0x0, dwb write 0x100 = 0x12345678, sel 0xF) -> iwb served first, then dwb after one IDLE cycle; a later read of 0x100 returns 0x12345678; grants 01, 00, 10.
- Both masters hold requests for 8 transfers -> grant sequence strictly alternates i, d, i, d…; no slave stb in any cycle following an ack; exactly 8 slave acks.
- Slave never acks, TIMEOUT = 4, dwb requests -> io_dwb_err is a single pulse on the 4th BUSY cycle; io_swb_stb is 0 that cycle; FSM returns to IDLE; the next iwb request is granted normally.
- dwb drops cyc one cycle into BUSY -> FSM goes to IDLE, no ack/err to dwb; the slave's late ack the following cycle does not reach either master.
- reset asserted while BUSY with iwb -> next cycle all outputs 0 and grant 00; the pending slave ack is dropped; after reset, a tie grants iwb first.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the CPU-side interconnect: widths, arbiter
// state encoding, master indices and request/response bundles.
package wb_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    localparam int GNT_I = 0;
    localparam int GNT_D = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [AW_DEF-1:0]   addr;
        logic [DW_DEF-1:0]   wdata;
        logic [DW_DEF/8-1:0] sel;
        logic                we;
        logic                cyc;
        logic                stb;
    } wb_req_t;

    typedef struct packed {
        logic [DW_DEF-1:0] rdata;
        logic              ack;
        logic              err;
    } wb_rsp_t;

    function automatic logic wb_is_req(input logic cyc, input logic stb);
        return cyc & stb;
    endfunction

endpackage

// File: rtl/wb_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that was not served last.
module wb_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master (iwb/dwb) to one-slave Wishbone classic arbiter with round-robin
// grant, one transfer per grant and a bus-timeout watchdog.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [AW-1:0]     io_iwb_addr,
    input  logic [DW-1:0]     io_iwb_wdata,
    input  logic [DW/8-1:0]   io_iwb_sel,
    input  logic              io_iwb_we,
    input  logic              io_iwb_cyc,
    input  logic              io_iwb_stb,
    output logic [DW-1:0]     io_iwb_rdata,
    output logic              io_iwb_ack,
    output logic              io_iwb_err,

    input  logic [AW-1:0]     io_dwb_addr,
    input  logic [DW-1:0]     io_dwb_wdata,
    input  logic [DW/8-1:0]   io_dwb_sel,
    input  logic              io_dwb_we,
    input  logic              io_dwb_cyc,
    input  logic              io_dwb_stb,
    output logic [DW-1:0]     io_dwb_rdata,
    output logic              io_dwb_ack,
    output logic              io_dwb_err,

    output logic [AW-1:0]     io_swb_addr,
    output logic [DW-1:0]     io_swb_wdata,
    output logic [DW/8-1:0]   io_swb_sel,
    output logic              io_swb_we,
    output logic              io_swb_cyc,
    output logic              io_swb_stb,
    input  logic [DW-1:0]     io_swb_rdata,
    input  logic              io_swb_ack,

    output logic [1:0]        io_grant
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    arb_state_t    state_reg, state_next;
    logic          grant_d_reg, grant_d_next;
    logic          last_d_reg, last_d_next;
    logic [TW-1:0] tmo_reg, tmo_next;

    logic [AW-1:0]   m_addr  [2];
    logic [DW-1:0]   m_wdata [2];
    logic [DW/8-1:0] m_sel   [2];
    logic            m_we    [2];
    logic            m_cyc   [2];
    logic            m_stb   [2];
    logic [DW-1:0]   m_rdata [2];
    logic            m_ack   [2];
    logic            m_err   [2];

    logic [1:0] req;
    logic       pick_gnt, pick_valid;
    logic       busy, gnt_cyc, tmo_hit;

    assign m_addr[GNT_I]  = io_iwb_addr;
    assign m_wdata[GNT_I] = io_iwb_wdata;
    assign m_sel[GNT_I]   = io_iwb_sel;
    assign m_we[GNT_I]    = io_iwb_we;
    assign m_cyc[GNT_I]   = io_iwb_cyc;
    assign m_stb[GNT_I]   = io_iwb_stb;
    assign m_addr[GNT_D]  = io_dwb_addr;
    assign m_wdata[GNT_D] = io_dwb_wdata;
    assign m_sel[GNT_D]   = io_dwb_sel;
    assign m_we[GNT_D]    = io_dwb_we;
    assign m_cyc[GNT_D]   = io_dwb_cyc;
    assign m_stb[GNT_D]   = io_dwb_stb;

    assign io_iwb_rdata = m_rdata[GNT_I];
    assign io_iwb_ack   = m_ack[GNT_I];
    assign io_iwb_err   = m_err[GNT_I];
    assign io_dwb_rdata = m_rdata[GNT_D];
    assign io_dwb_ack   = m_ack[GNT_D];
    assign io_dwb_err   = m_err[GNT_D];

    assign busy    = (state_reg == ST_BUSY);
    assign gnt_cyc = m_cyc[grant_d_reg];
    assign tmo_hit = (TIMEOUT != 0) && busy && (tmo_reg == TMO_LAST);

    // Responses go only to the owner, and never to a master that dropped cyc.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic owns;
        assign req[gi]     = wb_is_req(m_cyc[gi], m_stb[gi]);
        assign owns        = busy && (grant_d_reg == 1'(gi));
        assign m_rdata[gi] = owns ? io_swb_rdata : '0;
        assign m_ack[gi]   = owns & m_cyc[gi] & io_swb_ack;
        assign m_err[gi]   = owns & m_cyc[gi] & ~io_swb_ack & tmo_hit;
    end

    wb_rr_pick2 u_pick (
        .req   (req),
        .last  (last_d_reg),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // stb is dropped on the timeout cycle itself; gating on tmo_hit alone
    // keeps slave ack out of the stb path.
    always_comb begin
        io_swb_addr  = '0;
        io_swb_wdata = '0;
        io_swb_sel   = '0;
        io_swb_we    = 1'b0;
        io_swb_cyc   = 1'b0;
        io_swb_stb   = 1'b0;
        if (busy) begin
            io_swb_addr  = m_addr[grant_d_reg];
            io_swb_wdata = m_wdata[grant_d_reg];
            io_swb_sel   = m_sel[grant_d_reg];
            io_swb_we    = m_we[grant_d_reg];
            io_swb_cyc   = m_cyc[grant_d_reg];
            io_swb_stb   = m_stb[grant_d_reg] & ~tmo_hit;
        end
    end

    assign io_grant = busy ? (2'b01 << grant_d_reg) : 2'b00;

    always_comb begin
        state_next   = state_reg;
        grant_d_next = grant_d_reg;
        last_d_next  = last_d_reg;
        tmo_next     = tmo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next   = ST_BUSY;
                    grant_d_next = pick_gnt;
                    tmo_next     = '0;
                end
            end
            ST_BUSY: begin
                if (io_swb_ack || !gnt_cyc || tmo_hit) begin
                    state_next  = ST_IDLE;
                    last_d_next = grant_d_reg;
                end else if (tmo_reg != {TW{1'b1}}) begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            grant_d_reg <= 1'b0;
            last_d_reg  <= 1'b1;
            tmo_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            grant_d_reg <= grant_d_next;
            last_d_reg  <= last_d_next;
            tmo_reg     <= tmo_next;
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Randomised and directed bench for wb_arbiter2 against an ownership-level
// reference model, with a wb_ram-style slave living in the bench.
module tb_wb_arbiter2;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_sel   [2];
    logic        m_we    [2];
    logic        m_cyc   [2];
    logic        m_stb   [2];

    logic [31:0] iwb_rdata, dwb_rdata;
    logic        iwb_ack, iwb_err, dwb_ack, dwb_err;
    logic [31:0] swb_addr, swb_wdata, swb_rdata;
    logic [3:0]  swb_sel;
    logic        swb_we, swb_cyc, swb_stb, swb_ack;
    logic [1:0]  grant;

    wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .clock        (clk),
        .reset        (rst),
        .io_iwb_addr  (m_addr[0]),
        .io_iwb_wdata (m_wdata[0]),
        .io_iwb_sel   (m_sel[0]),
        .io_iwb_we    (m_we[0]),
        .io_iwb_cyc   (m_cyc[0]),
        .io_iwb_stb   (m_stb[0]),
        .io_iwb_rdata (iwb_rdata),
        .io_iwb_ack   (iwb_ack),
        .io_iwb_err   (iwb_err),
        .io_dwb_addr  (m_addr[1]),
        .io_dwb_wdata (m_wdata[1]),
        .io_dwb_sel   (m_sel[1]),
        .io_dwb_we    (m_we[1]),
        .io_dwb_cyc   (m_cyc[1]),
        .io_dwb_stb   (m_stb[1]),
        .io_dwb_rdata (dwb_rdata),
        .io_dwb_ack   (dwb_ack),
        .io_dwb_err   (dwb_err),
        .io_swb_addr  (swb_addr),
        .io_swb_wdata (swb_wdata),
        .io_swb_sel   (swb_sel),
        .io_swb_we    (swb_we),
        .io_swb_cyc   (swb_cyc),
        .io_swb_stb   (swb_stb),
        .io_swb_rdata (swb_rdata),
        .io_swb_ack   (swb_ack),
        .io_grant     (grant)
    );

    // Slave: registered ack guarded by ~ack, optional wait states, stray-ack injection.
    logic [31:0] mem [256];
    logic        ack_r = 1'b0;
    logic [31:0] rdat_r = 32'h0;
    int          dcnt = 0;
    bit          slv_en = 1'b1;
    int          slv_delay = 0;
    bit          stray = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'hA500_0000 | 32'(k);
            mem[4] <= 32'hDEADBEEF;
            ack_r  <= 1'b0;
            dcnt   <= 0;
        end else if (slv_en && swb_cyc && swb_stb && !ack_r) begin
            if (dcnt >= slv_delay) begin
                ack_r  <= 1'b1;
                dcnt   <= 0;
                rdat_r <= mem[swb_addr[9:2]];
                if (swb_we)
                    for (int b = 0; b < 4; b++)
                        if (swb_sel[b]) mem[swb_addr[9:2]][8*b +: 8] <= swb_wdata[8*b +: 8];
            end else begin
                ack_r <= 1'b0;
                dcnt  <= dcnt + 1;
            end
        end else begin
            ack_r <= 1'b0;
            dcnt  <= 0;
        end
    end

    assign swb_ack   = ack_r | stray;
    assign swb_rdata = rdat_r;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who was served last, how long the owner has waited.
    int  own = -1;
    int  last_srv = 1;
    int  age = 0;
    bit  mdl_ok = 1'b0;
    bit  prev_end_ack = 1'b0;
    bit  seen_ack [2] = '{1'b0, 1'b0};
    bit  seen_err [2] = '{1'b0, 1'b0};
    int  swb_ack_cnt = 0;

    always @(negedge clk) begin
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_sel;
        logic        e_we, e_cyc, e_stb;
        logic [1:0]  e_grant;
        logic        e_ack [2];
        logic        e_err [2];
        logic [31:0] e_rd  [2];
        bit          hit, r0, r1;
        if (mdl_ok) begin
            e_addr = '0; e_wdata = '0; e_sel = '0; e_we = 0; e_cyc = 0; e_stb = 0;
            e_grant = 2'b00; hit = 0;
            for (int i = 0; i < 2; i++) begin e_ack[i] = 0; e_err[i] = 0; e_rd[i] = '0; end
            if (own >= 0) begin
                hit        = (age == TMO - 1);
                e_grant    = (own == 0) ? 2'b01 : 2'b10;
                e_addr     = m_addr[own];
                e_wdata    = m_wdata[own];
                e_sel      = m_sel[own];
                e_we       = m_we[own];
                e_cyc      = m_cyc[own];
                e_stb      = m_stb[own] && !hit;
                e_ack[own] = swb_ack && m_cyc[own];
                e_err[own] = m_cyc[own] && !swb_ack && hit;
                e_rd[own]  = swb_rdata;
            end
            chk("grant", grant, e_grant);
            chk("swb_addr", swb_addr, e_addr);
            chk("swb_wdata", swb_wdata, e_wdata);
            chk("swb_sel", swb_sel, e_sel);
            chk("swb_we", swb_we, e_we);
            chk("swb_cyc", swb_cyc, e_cyc);
            chk("swb_stb", swb_stb, e_stb);
            chk("iwb_ack", iwb_ack, e_ack[0]);
            chk("iwb_err", iwb_err, e_err[0]);
            chk("iwb_rdata", iwb_rdata, e_rd[0]);
            chk("dwb_ack", dwb_ack, e_ack[1]);
            chk("dwb_err", dwb_err, e_err[1]);
            chk("dwb_rdata", dwb_rdata, e_rd[1]);
            if (prev_end_ack) chk("stb_after_ack", swb_stb, 1'b0);
            if (own >= 0 && (iwb_ack || dwb_ack || iwb_err || dwb_err))
                $display("xfer %s %s we=%0d addr=%h wdata=%h rdata=%h", (own == 0) ? "iwb" : "dwb",
                         (iwb_err || dwb_err) ? "err" : "ack", swb_we, swb_addr, swb_wdata, swb_rdata);
        end
        prev_end_ack = (own >= 0) && swb_ack;
        seen_ack[0] = iwb_ack; seen_ack[1] = dwb_ack;
        seen_err[0] = iwb_err; seen_err[1] = dwb_err;
        if (swb_ack) swb_ack_cnt++;
        if (rst) begin
            own = -1; last_srv = 1; age = 0; mdl_ok = 1'b1;
        end else if (own < 0) begin
            r0 = m_cyc[0] && m_stb[0];
            r1 = m_cyc[1] && m_stb[1];
            if (r0 && r1) own = 1 - last_srv;
            else if (r0)  own = 0;
            else if (r1)  own = 1;
            age = 0;
        end else if (swb_ack || !m_cyc[own] || age == TMO - 1) begin
            last_srv = own;
            own = -1;
        end else begin
            age++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_m(input int i, input bit on, input logic [31:0] a, input bit we,
                         input logic [31:0] d, input logic [3:0] s);
        m_cyc[i] = on; m_stb[i] = on; m_addr[i] = a; m_we[i] = we; m_wdata[i] = d; m_sel[i] = s;
    endtask

    bit act [2];
    int n_done, cur, start_cnt;

    initial begin
        for (int i = 0; i < 2; i++) begin set_m(i, 0, 0, 0, 0, 4'h0); act[i] = 0; end
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // iwb read of 0x10 from reset
        set_m(0, 1, 32'h10, 0, 0, 4'hF);
        at_neg(); chk("s1_idle_grant", grant, 2'b00); chk("s1_idle_stb", swb_stb, 1'b0);
        tick(); at_neg(); chk("s1_grant", grant, 2'b01); chk("s1_stb", swb_stb, 1'b1); chk("s1_early_ack", iwb_ack, 1'b0);
        tick(); at_neg(); chk("s1_ack", iwb_ack, 1'b1); chk("s1_rdata", iwb_rdata, 32'hDEADBEEF);
        chk("s1_dwb_ack", dwb_ack, 1'b0); chk("s1_grant_b", grant, 2'b01);
        tick(); set_m(0, 0, 0, 0, 0, 4'h0);
        at_neg(); chk("s1_after_grant", grant, 2'b00); chk("s1_after_stb", swb_stb, 1'b0);

        // tie from reset: iwb read 0x0 first, then dwb write 0x100
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        set_m(0, 1, 32'h0, 0, 0, 4'hF);
        set_m(1, 1, 32'h100, 1, 32'h12345678, 4'hF);
        at_neg(); chk("s2_c0_grant", grant, 2'b00);
        tick(); at_neg(); chk("s2_c1_grant", grant, 2'b01); chk("s2_c1_addr", swb_addr, 32'h0);
        tick(); at_neg(); chk("s2_c2_iack", iwb_ack, 1'b1);
        tick(); set_m(0, 0, 0, 0, 0, 4'h0);
        at_neg(); chk("s2_c3_grant", grant, 2'b00); chk("s2_c3_stb", swb_stb, 1'b0);
        tick(); at_neg(); chk("s2_c4_grant", grant, 2'b10); chk("s2_c4_we", swb_we, 1'b1); chk("s2_c4_addr", swb_addr, 32'h100);
        tick(); at_neg(); chk("s2_c5_dack", dwb_ack, 1'b1);
        tick(); set_m(1, 0, 0, 0, 0, 4'h0); set_m(0, 1, 32'h100, 0, 0, 4'hF);
        at_neg(); chk("s2_c6_grant", grant, 2'b00);
        tick(); at_neg(); chk("s2_c7_grant", grant, 2'b01);
        tick(); at_neg(); chk("s2_rb_ack", iwb_ack, 1'b1); chk("s2_rb_data", iwb_rdata, 32'h12345678);
        tick(); set_m(0, 0, 0, 0, 0, 4'h0);

        // both masters hold requests for 8 transfers; last served was iwb so dwb leads
        set_m(0, 1, 32'h20, 0, 0, 4'hF);
        set_m(1, 1, 32'h24, 0, 0, 4'hF);
        start_cnt = swb_ack_cnt;
        n_done = 0;
        for (int c = 0; c < 100 && n_done < 8; c++) begin
            at_neg();
            if (iwb_ack || dwb_ack) begin
                cur = dwb_ack ? 1 : 0;
                chk("s3_owner", cur, (n_done % 2 == 0) ? 1 : 0);
                n_done++;
            end
            tick();
        end
        set_m(0, 0, 0, 0, 0, 4'h0); set_m(1, 0, 0, 0, 0, 4'h0);
        chk("s3_xfers", n_done, 8);
        repeat (2) tick();
        chk("s3_slave_acks", swb_ack_cnt - start_cnt, 8);

        // watchdog: slave silent, dwb gets err on the 4th BUSY cycle
        slv_en = 1'b0;
        set_m(1, 1, 32'h80, 0, 0, 4'hF);
        at_neg(); chk("s4_c0_grant", grant, 2'b00);
        for (int k = 1; k <= 4; k++) begin
            tick(); at_neg();
            chk("s4_grant", grant, 2'b10);
            chk("s4_err", dwb_err, (k == 4) ? 1'b1 : 1'b0);
            chk("s4_stb", swb_stb, (k == 4) ? 1'b0 : 1'b1);
        end
        chk("s4_cyc", swb_cyc, 1'b1);
        tick(); set_m(1, 0, 0, 0, 0, 4'h0); slv_en = 1'b1; set_m(0, 1, 32'h10, 0, 0, 4'hF);
        at_neg(); chk("s4_idle_grant", grant, 2'b00); chk("s4_idle_err", dwb_err, 1'b0);
        tick(); at_neg(); chk("s4_next_grant", grant, 2'b01);
        tick(); at_neg(); chk("s4_next_ack", iwb_ack, 1'b1); chk("s4_next_rdata", iwb_rdata, 32'hDEADBEEF);
        tick(); set_m(0, 0, 0, 0, 0, 4'h0);

        // dwb aborts one cycle into BUSY; a late ack must not be routed
        slv_en = 1'b0;
        set_m(1, 1, 32'h84, 0, 0, 4'hF);
        tick(); at_neg(); chk("s5_grant", grant, 2'b10);
        tick(); m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        at_neg(); chk("s5_abort_ack", dwb_ack, 1'b0); chk("s5_abort_err", dwb_err, 1'b0); chk("s5_abort_cyc", swb_cyc, 1'b0);
        tick(); stray = 1'b1;
        at_neg(); chk("s5_late_grant", grant, 2'b00); chk("s5_late_iack", iwb_ack, 1'b0);
        chk("s5_late_dack", dwb_ack, 1'b0); chk("s5_late_drd", dwb_rdata, 32'h0);
        tick(); stray = 1'b0; slv_en = 1'b1;

        // reset while BUSY with iwb; pending ack swallowed, tie afterwards goes to iwb
        slv_delay = 1;
        set_m(0, 1, 32'h10, 0, 0, 4'hF);
        tick(); at_neg(); chk("s6_grant", grant, 2'b01);
        tick(); rst = 1'b1;
        at_neg(); chk("s6_busy_grant", grant, 2'b01);
        tick(); rst = 1'b0; set_m(1, 1, 32'h88, 0, 0, 4'hF);
        at_neg(); chk("s6_rst_grant", grant, 2'b00); chk("s6_rst_cyc", swb_cyc, 1'b0);
        chk("s6_rst_stb", swb_stb, 1'b0); chk("s6_rst_iack", iwb_ack, 1'b0); chk("s6_rst_dack", dwb_ack, 1'b0);
        tick(); at_neg(); chk("s6_tie_grant", grant, 2'b01);
        tick(); set_m(0, 0, 0, 0, 0, 4'h0); set_m(1, 0, 0, 0, 0, 4'h0);
        slv_delay = 0;
        repeat (3) tick();

        // randomised traffic: waits, aborts, timeouts, stray acks, resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst   = ($urandom_range(0, 299) == 0);
            stray = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < 2; i++) begin
                if (act[i] && (seen_ack[i] || seen_err[i] || $urandom_range(0, 31) == 0)) act[i] = 0;
                if (!act[i] && $urandom_range(0, 2) == 0) begin
                    act[i]     = 1;
                    m_addr[i]  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                    m_wdata[i] = $urandom();
                    m_sel[i]   = 4'($urandom_range(1, 15));
                    m_we[i]    = 1'($urandom_range(0, 1));
                    slv_delay  = $urandom_range(0, 3);
                end
                m_cyc[i] = act[i] ? 1'b1 : ($urandom_range(0, 7) == 0);
                m_stb[i] = act[i];
            end
        end
        tick();
        rst = 1'b0; stray = 1'b0;
        set_m(0, 0, 0, 0, 0, 4'h0); set_m(1, 0, 0, 0, 0, 4'h0);
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
